// File: rtl/mux_nx1_pipe.sv
// mux_nx1_pipe: N-input, WIDTH-bit selector with a registered output and a
// valid/ready handshake on both sides. A two-entry store (output register
// plus one skid register) gives full throughput while in_ready comes
// straight from a flop, so there is no combinational ready path from the
// consumer back to the producer. An out-of-range select yields a zero word
// with out_err set instead of aliasing onto a real input.
module mux_nx1_pipe #(
    parameter int WIDTH = 32,
    parameter int N_IN  = 4,
    parameter int SEL_W = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [SEL_W-1:0]      sel,
    input  logic [N_IN*WIDTH-1:0] data_in,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WIDTH-1:0]      data_out,
    output logic                  out_err
);

    // EMPTY: nothing held; ONE: word in OUT; FULL: words in OUT and SKD.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t             state_reg;
    logic [WIDTH-1:0]   out_data_reg;
    logic               out_err_reg;
    logic [WIDTH-1:0]   skd_data_reg;
    logic               skd_err_reg;
    logic               in_ready_reg;
    logic               out_valid_reg;

    logic [WIDTH-1:0]   in_words [N_IN];
    logic [WIDTH-1:0]   sel_word;
    logic               sel_err;
    logic               accept;
    logic               drain;

    // Unpack the flat input bus into one word per input.
    generate
        for (genvar gi = 0; gi < N_IN; gi++) begin : g_unpack
            assign in_words[gi] = data_in[gi*WIDTH +: WIDTH];
        end
    endgenerate

    // Select the addressed word; any index with no matching input gives 0 and err.
    always_comb begin
        sel_word = '0;
        sel_err  = 1'b1;
        for (int k = 0; k < N_IN; k++) begin
            if (32'(sel) == k) begin
                sel_word = in_words[k];
                sel_err  = 1'b0;
            end
        end
    end

    assign accept = in_valid & in_ready_reg;
    assign drain  = out_valid_reg & out_ready;

    // Handshake state machine; registers load only on accept/drain, so
    // sel/data_in are ignored whenever in_valid is low.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= EMPTY;
            in_ready_reg  <= 1'b1;
            out_valid_reg <= 1'b0;
            out_data_reg  <= '0;
            out_err_reg   <= 1'b0;
            skd_data_reg  <= '0;
            skd_err_reg   <= 1'b0;
        end else begin
            unique case (state_reg)
                EMPTY: begin
                    if (accept) begin
                        out_data_reg  <= sel_word;
                        out_err_reg   <= sel_err;
                        out_valid_reg <= 1'b1;
                        state_reg     <= ONE;
                    end
                end
                ONE: begin
                    if (accept && drain) begin
                        out_data_reg <= sel_word;
                        out_err_reg  <= sel_err;
                    end else if (accept) begin
                        skd_data_reg <= sel_word;
                        skd_err_reg  <= sel_err;
                        in_ready_reg <= 1'b0;
                        state_reg    <= FULL;
                    end else if (drain) begin
                        out_valid_reg <= 1'b0;
                        state_reg     <= EMPTY;
                    end
                end
                FULL: begin
                    // in_ready is low here, so only a drain can move things.
                    if (drain) begin
                        out_data_reg <= skd_data_reg;
                        out_err_reg  <= skd_err_reg;
                        in_ready_reg <= 1'b1;
                        state_reg    <= ONE;
                    end
                end
                default: begin
                    in_ready_reg  <= 1'b1;
                    out_valid_reg <= 1'b0;
                    state_reg     <= EMPTY;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_reg;
    assign out_valid = out_valid_reg;
    assign data_out  = out_data_reg;
    assign out_err   = out_err_reg;

endmodule

// File: tb/tb_mux_nx1_pipe.sv
// Bench for mux_nx1_pipe: three instances (32b x 4 inputs, 32b x 3 inputs,
// 8b x 16 inputs) driven by per-scenario tasks with a queue scoreboard.
module tb_mux_nx1_pipe;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Instance A: WIDTH=32, N_IN=4
    logic         a_in_valid, a_in_ready, a_out_valid, a_out_ready, a_out_err;
    logic [1:0]   a_sel;
    logic [127:0] a_data_in;
    logic [31:0]  a_data_out;
    // Instance B: WIDTH=32, N_IN=3
    logic         b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_out_err;
    logic [1:0]   b_sel;
    logic [95:0]  b_data_in;
    logic [31:0]  b_data_out;
    // Instance C: WIDTH=8, N_IN=16
    logic         c_in_valid, c_in_ready, c_out_valid, c_out_ready, c_out_err;
    logic [3:0]   c_sel;
    logic [127:0] c_data_in;
    logic [7:0]   c_data_out;

    logic [32:0] q_a[$];
    logic [32:0] q_b[$];
    logic [8:0]  q_c[$];

    mux_nx1_pipe #(.WIDTH(32), .N_IN(4), .SEL_W(2)) u_a (
        .clk(clk), .rst(rst), .in_valid(a_in_valid), .in_ready(a_in_ready),
        .sel(a_sel), .data_in(a_data_in), .out_valid(a_out_valid),
        .out_ready(a_out_ready), .data_out(a_data_out), .out_err(a_out_err));

    mux_nx1_pipe #(.WIDTH(32), .N_IN(3), .SEL_W(2)) u_b (
        .clk(clk), .rst(rst), .in_valid(b_in_valid), .in_ready(b_in_ready),
        .sel(b_sel), .data_in(b_data_in), .out_valid(b_out_valid),
        .out_ready(b_out_ready), .data_out(b_data_out), .out_err(b_out_err));

    mux_nx1_pipe #(.WIDTH(8), .N_IN(16), .SEL_W(4)) u_c (
        .clk(clk), .rst(rst), .in_valid(c_in_valid), .in_ready(c_in_ready),
        .sel(c_sel), .data_in(c_data_in), .out_valid(c_out_valid),
        .out_ready(c_out_ready), .data_out(c_data_out), .out_err(c_out_err));

    // Reference models: {err, word}
    function automatic logic [32:0] model_a(input logic [1:0] s, input logic [127:0] d);
        return {1'b0, d[s*32 +: 32]};
    endfunction

    function automatic logic [32:0] model_b(input logic [1:0] s, input logic [95:0] d);
        logic [32:0] r;
        r = {1'b1, 32'h0};
        for (int k = 0; k < 3; k++)
            if (int'(s) == k) r = {1'b0, d[k*32 +: 32]};
        return r;
    endfunction

    function automatic logic [8:0] model_c(input logic [3:0] s, input logic [127:0] d);
        return {1'b0, d[s*8 +: 8]};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_data_out !== 32'h0 || a_out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_a: vld/rdy/data/err = %b/%b/%h/%b, need 0/1/0/0", a_out_valid, a_in_ready, a_data_out, a_out_err);
        end else $display("reset_a ok");
        checks++;
        if (b_out_valid !== 1'b0 || b_in_ready !== 1'b1 || b_data_out !== 32'h0 || b_out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_b: vld/rdy/data/err = %b/%b/%h/%b, need 0/1/0/0", b_out_valid, b_in_ready, b_data_out, b_out_err);
        end else $display("reset_b ok");
        checks++;
        if (c_out_valid !== 1'b0 || c_in_ready !== 1'b1 || c_data_out !== 8'h0 || c_out_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_c: vld/rdy/data/err = %b/%b/%h/%b, need 0/1/0/0", c_out_valid, c_in_ready, c_data_out, c_out_err);
        end else $display("reset_c ok");
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_after_reset: vld/rdy = %b/%b, need 0/1", a_out_valid, a_in_ready);
        end else $display("idle_after_reset ok");
    endtask

    task automatic test_select_sweep();
        logic [32:0] exp;
        a_out_ready = 1'b1;
        a_data_in = {32'h33333333, 32'h22222222, 32'h11111111, 32'h00000000};
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_sel = 2'd0;
        q_a.push_back(model_a(a_sel, a_data_in));
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            exp = q_a.pop_front();
            checks++;
            if (a_out_valid !== 1'b1 || a_in_ready !== 1'b1 || {a_out_err, a_data_out} !== exp) begin
                errors++;
                $display("FAIL sweep_sel%0d: vld=%b rdy=%b err/data=%h, need 1 1 %h", i, a_out_valid, a_in_ready, {a_out_err, a_data_out}, exp);
            end else $display("sweep sel=%0d data=%h", i, a_data_out);
            if (i < 3) begin
                a_sel = 2'(i + 1);
                q_a.push_back(model_a(a_sel, a_data_in));
            end else begin
                a_in_valid = 1'b0;
            end
        end
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drained: out_valid=%b, need 0", a_out_valid);
        end else $display("sweep drained");
    endtask

    task automatic test_out_of_range();
        logic [32:0] exp;
        logic [1:0]  sels [5];
        sels = '{2'd3, 2'd1, 2'd2, 2'd0, 2'd3};
        b_out_ready = 1'b1;
        b_data_in = {32'hA2A2A2A2, 32'hA1A1A1A1, 32'hA0A0A0A0};
        @(posedge clk); #1;
        b_in_valid = 1'b1;
        b_sel = sels[0];
        q_b.push_back(model_b(b_sel, b_data_in));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            exp = q_b.pop_front();
            checks++;
            if (b_out_valid !== 1'b1 || {b_out_err, b_data_out} !== exp) begin
                errors++;
                $display("FAIL range_step%0d: vld=%b err/data=%h, need 1 %h", i, b_out_valid, {b_out_err, b_data_out}, exp);
            end else $display("range sel=%0d err=%b data=%h", sels[i], b_out_err, b_data_out);
            if (i < 4) begin
                b_sel = sels[i + 1];
                q_b.push_back(model_b(b_sel, b_data_in));
            end else begin
                b_in_valid = 1'b0;
            end
        end
    endtask

    task automatic test_backpressure();
        logic [32:0] exp;
        a_out_ready = 1'b0;
        a_data_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_sel = 2'd0;
        q_a.push_back(model_a(a_sel, a_data_in));          // A
        @(posedge clk); #1;
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || {a_out_err, a_data_out} !== q_a[0]) begin
            errors++;
            $display("FAIL bp_push_a: rdy=%b vld=%b err/data=%h, need 1 1 %h", a_in_ready, a_out_valid, {a_out_err, a_data_out}, q_a[0]);
        end else $display("bp push A data=%h", a_data_out);
        a_sel = 2'd1;
        q_a.push_back(model_a(a_sel, a_data_in));          // B
        @(posedge clk); #1;
        a_sel = 2'd2;                                       // C offered while full
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1 || {a_out_err, a_data_out} !== q_a[0]) begin
                errors++;
                $display("FAIL bp_hold%0d: rdy=%b vld=%b err/data=%h, need 0 1 %h", i, a_in_ready, a_out_valid, {a_out_err, a_data_out}, q_a[0]);
            end else $display("bp hold cycle %0d data=%h", i, a_data_out);
            @(posedge clk); #1;
        end
        a_out_ready = 1'b1;
        @(posedge clk); #1;                                 // A drained, B in OUT
        exp = q_a.pop_front();
        q_a.push_back(model_a(a_sel, a_data_in));          // C accepted at next edge
        checks++;
        if (a_in_ready !== 1'b1 || a_out_valid !== 1'b1 || {a_out_err, a_data_out} !== q_a[0]) begin
            errors++;
            $display("FAIL bp_drain_a: rdy=%b vld=%b err/data=%h, need 1 1 %h", a_in_ready, a_out_valid, {a_out_err, a_data_out}, q_a[0]);
        end else $display("bp drained A=%h, now B=%h", exp[31:0], a_data_out);
        @(posedge clk); #1;                                 // B drained, C in OUT
        a_in_valid = 1'b0;
        exp = q_a.pop_front();
        checks++;
        if (a_out_valid !== 1'b1 || {a_out_err, a_data_out} !== q_a[0]) begin
            errors++;
            $display("FAIL bp_drain_b: vld=%b err/data=%h, need 1 %h", a_out_valid, {a_out_err, a_data_out}, q_a[0]);
        end else $display("bp drained B=%h, now C=%h", exp[31:0], a_data_out);
        @(posedge clk); #1;
        exp = q_a.pop_front();
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_empty: vld=%b rdy=%b, need 0 1", a_out_valid, a_in_ready);
        end else $display("bp drained C=%h, empty", exp[31:0]);
    endtask

    task automatic test_throughput();
        int n_out = 0;
        int n_in = 0;
        int rdy_low = 0;
        logic [32:0] exp;
        a_out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(posedge clk); #1;
            a_in_valid = 1'b1;
            a_sel = 2'($urandom);
            a_data_in = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            if (a_in_ready !== 1'b1) rdy_low++;
            else begin
                q_a.push_back(model_a(a_sel, a_data_in));
                n_in++;
            end
            if (a_out_valid === 1'b1) begin
                exp = q_a.pop_front();
                n_out++;
                checks++;
                if ({a_out_err, a_data_out} !== exp) begin
                    errors++;
                    $display("FAIL tput_word%0d: err/data=%h, need %h", n_out, {a_out_err, a_data_out}, exp);
                end else $display("tput word %0d data=%h", n_out, a_data_out);
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (a_out_valid !== 1'b1 || q_a.size() != 1 || {a_out_err, a_data_out} !== q_a[0]) begin
            errors++;
            $display("FAIL tput_last: vld=%b err/data=%h queued=%0d", a_out_valid, {a_out_err, a_data_out}, q_a.size());
        end else $display("tput last word data=%h", a_data_out);
        q_a.delete();
        @(posedge clk); #1;
        checks++;
        if (n_out != 99 || n_in != 100 || rdy_low != 0 || a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL tput_count: out=%0d in=%0d rdy_low=%0d vld=%b, need 99 100 0 0", n_out, n_in, rdy_low, a_out_valid);
        end else $display("tput 99 words in 100 cycles");
    endtask

    task automatic test_reset_midstream();
        a_out_ready = 1'b0;
        a_data_in = {$urandom, $urandom, $urandom, $urandom};
        @(posedge clk); #1;
        a_in_valid = 1'b1;
        a_sel = 2'd0;
        @(posedge clk); #1;
        a_sel = 2'd1;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        checks++;
        if (a_in_ready !== 1'b0 || a_out_valid !== 1'b1) begin
            errors++;
            $display("FAIL midrst_full: rdy=%b vld=%b, need 0 1", a_in_ready, a_out_valid);
        end else $display("midrst reached full");
        #2 rst = 1'b1;
        #1;
        checks++;
        if (a_out_valid !== 1'b0 || a_in_ready !== 1'b1 || a_data_out !== 32'h0 || a_out_err !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: vld/rdy/data/err = %b/%b/%h/%b, need 0/1/0/0", a_out_valid, a_in_ready, a_data_out, a_out_err);
        end else $display("midrst async clear");
        @(negedge clk);
        rst = 1'b0;
        q_a.delete();
        a_out_ready = 1'b1;
        a_in_valid = 1'b1;
        a_sel = 2'd2;
        q_a.push_back(model_a(a_sel, a_data_in));
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        checks++;
        if (a_out_valid !== 1'b1 || {a_out_err, a_data_out} !== q_a[0]) begin
            errors++;
            $display("FAIL midrst_first: vld=%b err/data=%h, need 1 %h", a_out_valid, {a_out_err, a_data_out}, q_a[0]);
        end else $display("midrst first word data=%h", a_data_out);
        void'(q_a.pop_front());
        @(posedge clk); #1;
        checks++;
        if (a_out_valid !== 1'b0) begin
            errors++;
            $display("FAIL midrst_nodup: vld=%b, need 0", a_out_valid);
        end else $display("midrst held words discarded");
    endtask

    task automatic test_random();
        int pushed = 0;
        int popped = 0;
        int cycles = 0;
        logic prev_hold = 1'b0;
        logic [8:0] prev_out = '0;
        logic [8:0] exp;
        while ((pushed < 10000 || q_c.size() != 0) && cycles < 60000) begin
            @(posedge clk); #1;
            cycles++;
            c_in_valid  = (pushed < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            c_sel       = 4'($urandom);
            c_data_in   = {$urandom, $urandom, $urandom, $urandom};
            c_out_ready = 1'($urandom_range(0, 1));
            @(negedge clk);
            if (prev_hold) begin
                checks++;
                if (c_out_valid !== 1'b1 || {c_out_err, c_data_out} !== prev_out) begin
                    errors++;
                    $display("FAIL rand_stable: vld=%b err/data=%h, need 1 %h", c_out_valid, {c_out_err, c_data_out}, prev_out);
                end
            end
            if (c_out_valid === 1'b1 && c_out_ready) begin
                checks++;
                if (q_c.size() == 0) begin
                    errors++;
                    $display("FAIL rand_extra: err/data=%h with empty scoreboard", {c_out_err, c_data_out});
                end else begin
                    exp = q_c.pop_front();
                    popped++;
                    if ({c_out_err, c_data_out} !== exp) begin
                        errors++;
                        $display("FAIL rand_word%0d: err/data=%h, need %h", popped, {c_out_err, c_data_out}, exp);
                    end else $display("rand word %0d data=%h", popped, c_data_out);
                end
            end
            if (c_in_valid && c_in_ready === 1'b1) begin
                q_c.push_back(model_c(c_sel, c_data_in));
                pushed++;
            end
            prev_hold = (c_out_valid === 1'b1) && !c_out_ready;
            prev_out  = {c_out_err, c_data_out};
        end
        c_in_valid = 1'b0;
        checks++;
        if (pushed != 10000 || popped != 10000 || q_c.size() != 0) begin
            errors++;
            $display("FAIL rand_count: pushed=%0d popped=%0d left=%0d cycles=%0d, need 10000 10000 0", pushed, popped, q_c.size(), cycles);
        end else $display("random 10000 words in %0d cycles", cycles);
    endtask

    initial begin
        rst = 1'b1;
        a_in_valid = 1'b0; a_out_ready = 1'b0; a_sel = '0; a_data_in = '0;
        b_in_valid = 1'b0; b_out_ready = 1'b0; b_sel = '0; b_data_in = '0;
        c_in_valid = 1'b0; c_out_ready = 1'b0; c_sel = '0; c_data_in = '0;
        test_reset();
        test_select_sweep();
        test_out_of_range();
        test_backpressure();
        test_throughput();
        test_reset_midstream();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
